mem_io_fabric: RTL

// - Parametrised successor to the fixed RAM/IO decoder: maps the CPU data bus onto N_REGIONS address windows
//   (data RAM, IO page, VRAM, ...), each with a programmable wait-state count and a cpu_ready handshake.
// - Latches unmapped accesses into a readable bus-error register block.
// - Sits between the CPU data port and all data-side slaves; slaves keep their own IO sub-decoding.

---
 rtl/mem_io_fabric_pkg.sv | 27 ++
 rtl/mem_io_decoder.sv | 45 ++++
 rtl/mem_io_fabric.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_fabric_pkg.sv
// Shared encodings for the CPU data-bus fabric: FSM states, read-source codes and error-block layout.
package mem_io_fabric_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int WAIT_W = 4;
    localparam int IDX_W  = 3;
    localparam int SRC_W  = 4;

    // Read-source codes above any region index
    localparam logic [SRC_W-1:0] RD_ERR  = 4'hE;
    localparam logic [SRC_W-1:0] RD_NONE = 4'hF;

    localparam logic [1:0] ERR_OFF_STATUS  = 2'd0;
    localparam logic [1:0] ERR_OFF_ADDR_LO = 2'd1;
    localparam logic [1:0] ERR_OFF_ADDR_HI = 2'd2;

    localparam int ERR_FLAG_BIT = 0;

    function automatic logic [7:0] err_status(input logic flag, input logic wr);
        return {6'b0, wr, flag};
    endfunction

endpackage

// File: rtl/mem_io_decoder.sv
// Combinational address decoder: error block first, then the lowest-index window containing the address.
module mem_io_decoder
    import mem_io_fabric_pkg::*;
#(
    parameter int                          N_REGIONS    = 4,
    parameter int                          ADDR_W       = 16,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h2000, 16'h1080, 16'h1000, 16'h0000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'h2960, 16'h10EF, 16'h107F, 16'h07FF},
    parameter logic [ADDR_W-1:0]           ERR_BASE     = 16'h10F0
) (
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic              err_hit,
    output logic [1:0]        err_off,
    output logic [ADDR_W-1:0] off_addr
);

    logic [ADDR_W-1:0] err_rel;
    logic [ADDR_W-1:0] base_sel;
    logic              region_hit;

    // Relative offset wraps modulo 2^ADDR_W, so a single compare covers the 3-byte block
    assign err_rel = cpu_addr - ERR_BASE;
    assign err_hit = (err_rel < ADDR_W'(3));
    assign err_off = err_rel[1:0];

    always_comb begin
        region_hit = 1'b0;
        idx        = '0;
        base_sel   = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((cpu_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                (cpu_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
                region_hit = 1'b1;
                idx        = IDX_W'(i);
                base_sel   = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hit      = region_hit && !err_hit;
    assign off_addr = cpu_addr - base_sel;

endmodule

// File: rtl/mem_io_fabric.sv
// CPU data-bus fabric: window decode, per-window wait states, read return and bus-error capture.
// Optional feature macro MEM_IO_ERR_IRQ_EN drives err_irq from a registered copy of the error flag.
module mem_io_fabric
    import mem_io_fabric_pkg::*;
#(
    parameter int                          N_REGIONS    = 4,
    parameter int                          ADDR_W       = 16,
    parameter int                          DATA_W       = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h2000, 16'h1080, 16'h1000, 16'h0000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'h2960, 16'h10EF, 16'h107F, 16'h07FF},
    parameter logic [N_REGIONS*4-1:0]      REGION_WAIT  = {4'd1, 4'd0, 4'd0, 4'd0},
    parameter logic [ADDR_W-1:0]           ERR_BASE     = 16'h10F0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_din,
    input  logic                        cpu_w_en,
    input  logic                        cpu_r_en,
    output logic [DATA_W-1:0]           cpu_dout,
    output logic                        cpu_ready,
    output logic [ADDR_W-1:0]           slv_addr,
    output logic [DATA_W-1:0]           slv_wdata,
    output logic [N_REGIONS-1:0]        slv_w_en,
    output logic [N_REGIONS-1:0]        slv_r_en,
    input  logic [N_REGIONS*DATA_W-1:0] slv_rdata,
    output logic                        err_irq
);

    localparam int EXT_W = (ADDR_W < 16) ? 16 : ADDR_W;

    logic              dec_hit, dec_err_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [1:0]        dec_err_off;
    logic [ADDR_W-1:0] dec_off;

    mem_io_decoder #(
        .N_REGIONS   (N_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_LIMIT(REGION_LIMIT),
        .ERR_BASE    (ERR_BASE)
    ) u_dec (
        .cpu_addr(cpu_addr),
        .hit     (dec_hit),
        .idx     (dec_idx),
        .err_hit (dec_err_hit),
        .err_off (dec_err_off),
        .off_addr(dec_off)
    );

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [SRC_W-1:0]  rd_src_q, rd_src_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        err_rdata_q, err_rdata_d;
    logic [DATA_W-1:0] dout_q;
    logic              err_flag_q, err_flag_d;
    logic              err_wr_q, err_wr_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              req, stb_en, err_set, err_clr, rd_done;
    logic [IDX_W-1:0]  stb_idx;
    logic [SRC_W-1:0]  rd_tgt;
    logic [WAIT_W-1:0] region_wait;
    logic [N_REGIONS-1:0] strobe;
    logic [EXT_W-1:0]  err_addr_ext;
    logic [7:0]        err_byte;
    logic [DATA_W-1:0] rd_live;

    assign req          = cpu_w_en | cpu_r_en;
    assign region_wait  = REGION_WAIT[int'(dec_idx)*WAIT_W +: WAIT_W];
    assign err_addr_ext = EXT_W'(err_addr_q);

    always_comb begin
        unique case (dec_err_off)
            ERR_OFF_STATUS:  err_byte = err_status(err_flag_q, err_wr_q);
            ERR_OFF_ADDR_LO: err_byte = err_addr_ext[7:0];
            ERR_OFF_ADDR_HI: err_byte = err_addr_ext[15:8];
            default:         err_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        rd_src_d    = rd_src_q;
        rd_pend_d   = 1'b0;
        err_rdata_d = err_rdata_q;
        cpu_ready   = 1'b0;
        stb_en      = 1'b0;
        stb_idx     = dec_idx;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        rd_done     = 1'b0;
        rd_tgt      = RD_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (dec_err_hit) begin
                        cpu_ready = 1'b1;
                        if (cpu_w_en) begin
                            err_clr = (dec_err_off == ERR_OFF_STATUS) && cpu_din[ERR_FLAG_BIT];
                        end else begin
                            rd_done     = 1'b1;
                            rd_tgt      = RD_ERR;
                            err_rdata_d = err_byte;
                        end
                    end else if (dec_hit) begin
                        if (region_wait == '0) begin
                            cpu_ready = 1'b1;
                            stb_en    = 1'b1;
                            rd_done   = !cpu_w_en;
                            rd_tgt    = {1'b0, dec_idx};
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = region_wait;
                            sel_d   = dec_idx;
                        end
                    end else begin
                        // Unmapped: complete at once; only the first error is kept
                        cpu_ready = 1'b1;
                        err_set   = !err_flag_q;
                        rd_done   = !cpu_w_en;
                        rd_tgt    = RD_NONE;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) begin
                    cpu_ready = 1'b1;
                    stb_en    = 1'b1;
                    stb_idx   = sel_q;
                    rd_done   = !cpu_w_en;
                    rd_tgt    = {1'b0, sel_q};
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rd_done) begin
            rd_src_d  = rd_tgt;
            rd_pend_d = 1'b1;
        end
    end

    always_comb begin
        err_flag_d = err_flag_q;
        err_wr_d   = err_wr_q;
        err_addr_d = err_addr_q;
        if (err_clr) err_flag_d = 1'b0;
        if (err_set) begin
            err_flag_d = 1'b1;
            err_wr_d   = cpu_w_en;
            err_addr_d = cpu_addr;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            strobe[i] = stb_en && (stb_idx == IDX_W'(i));
        end
    end

    assign slv_addr  = dec_off;
    assign slv_wdata = cpu_din;
    assign slv_w_en  = strobe & {N_REGIONS{cpu_w_en}};
    assign slv_r_en  = strobe & {N_REGIONS{cpu_r_en & ~cpu_w_en}};

    // Slave data arrives the cycle after the strobe; capture it then and hold it
    always_comb begin
        rd_live = '0;
        if (rd_src_q == RD_ERR) begin
            rd_live = DATA_W'(err_rdata_q);
        end else if ((rd_src_q != RD_NONE) && (int'(rd_src_q) < N_REGIONS)) begin
            rd_live = slv_rdata[int'(rd_src_q)*DATA_W +: DATA_W];
        end
    end

    assign cpu_dout = rd_pend_q ? rd_live : dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            rd_src_q    <= RD_NONE;
            rd_pend_q   <= 1'b0;
            err_rdata_q <= '0;
            dout_q      <= '0;
            err_flag_q  <= 1'b0;
            err_wr_q    <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            rd_src_q    <= rd_src_d;
            rd_pend_q   <= rd_pend_d;
            err_rdata_q <= err_rdata_d;
            if (rd_pend_q) dout_q <= rd_live;
            err_flag_q  <= err_flag_d;
            err_wr_q    <= err_wr_d;
            err_addr_q  <= err_addr_d;
        end
    end

`ifdef MEM_IO_ERR_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= err_flag_q;
    end
    assign err_irq = irq_q;
`else
    assign err_irq = 1'b0;
`endif

endmodule
